// File: rtl/ascensor_pkg.sv
// Shared encodings and SCAN helper functions for the elevator controller.
package ascensor_pkg;

   localparam int unsigned MAX_PISOS  = 16;
   localparam int unsigned MAX_PISO_W = 4;

   // State encoding doubles as the accion output encoding
   typedef enum logic [1:0] {
      REPOSO   = 2'b00,
      SUBIENDO = 2'b01,
      BAJANDO  = 2'b10,
      PUERTA   = 2'b11
   } estado_e;

   typedef enum logic {
      DIR_BAJA = 1'b0,
      DIR_SUBE = 1'b1
   } dir_e;

   // Result of a SCAN direction decision
   typedef struct packed {
      estado_e estado;
      dir_e    dir;
   } decision_t;

   // Any pending call strictly above the given floor
   function automatic logic hay_arriba(input logic [MAX_PISOS-1:0]  mask,
                                       input logic [MAX_PISO_W-1:0] piso);
      logic r;
      r = 1'b0;
      for (int unsigned i = 0; i < MAX_PISOS; i++) begin
         if ((i > 32'(piso)) && mask[MAX_PISO_W'(i)]) r = 1'b1;
      end
      return r;
   endfunction

   // Any pending call strictly below the given floor
   function automatic logic hay_abajo(input logic [MAX_PISOS-1:0]  mask,
                                      input logic [MAX_PISO_W-1:0] piso);
      logic r;
      r = 1'b0;
      for (int unsigned i = 0; i < MAX_PISOS; i++) begin
         if ((i < 32'(piso)) && mask[MAX_PISO_W'(i)]) r = 1'b1;
      end
      return r;
   endfunction

   // Keep going the last way if work lies ahead, else reverse, else rest
   function automatic decision_t decidir(input logic arriba,
                                         input logic abajo,
                                         input dir_e dir);
      decision_t d;
      d.estado = REPOSO;
      d.dir    = dir;
      if (arriba && ((dir == DIR_SUBE) || !abajo)) begin
         d.estado = SUBIENDO;
         d.dir    = DIR_SUBE;
      end else if (abajo) begin
         d.estado = BAJANDO;
         d.dir    = DIR_BAJA;
      end
      return d;
   endfunction

endpackage

// File: rtl/temporizador.sv
// Loadable down-counter shared by travel and door timing; expires on count 1.
module temporizador #(
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] valor,
   output logic         expira_c
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Load has priority; otherwise count down while enabled, saturating at 0
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = valor;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expira_c = (cnt_q == W'(1));

endmodule

// File: rtl/maquina_estados_scan.sv
// N-floor elevator controller: latched call mask, SCAN sweep, timed travel and door.
module maquina_estados_scan
   import ascensor_pkg::*;
#(
   parameter  int unsigned N_PISOS  = 4,
   parameter  int unsigned T_VIAJE  = 2,
   parameter  int unsigned T_PUERTA = 4,
   localparam int unsigned PISO_W   = $clog2(N_PISOS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               sol_valida,
   input  logic [PISO_W-1:0]  sol_piso,
   output logic [PISO_W-1:0]  piso,
   output logic [1:0]         accion,
   output logic               puertas,
   output logic [N_PISOS-1:0] pendientes
);

   localparam int unsigned T_MAX = (T_VIAJE > T_PUERTA) ? T_VIAJE : T_PUERTA;
   localparam int unsigned TMR_W = $clog2(T_MAX + 1);

   estado_e             estado_q, estado_d;
   logic [PISO_W-1:0]   piso_q, piso_d;
   dir_e                dir_q, dir_d;
   logic [N_PISOS-1:0]  pend_q, pend_d;
   logic                puertas_q, puertas_d;

   logic                tmr_load;
   logic                tmr_dec;
   logic [TMR_W-1:0]    tmr_val;
   logic                tmr_expira_c;

   logic                llamada_ok_c;
   logic                misma_c;
   logic                absorbe_c;
   logic                arriba_c;
   logic                abajo_c;
   decision_t           dec_c;
   logic [PISO_W-1:0]   nuevo_c;
   logic                llegada_pend_c;

   // Shared travel/door timer
   temporizador #(
      .W (TMR_W)
   ) u_tmr (
      .clk      (clk),
      .rst_n    (rst),
      .en       (tmr_dec),
      .load     (tmr_load),
      .valor    (tmr_val),
      .expira_c (tmr_expira_c)
   );

   // Call qualification and SCAN look-ahead from the registered mask
   assign llamada_ok_c   = sol_valida && (32'(sol_piso) < N_PISOS);
   assign misma_c        = llamada_ok_c && (sol_piso == piso_q);
   assign absorbe_c      = misma_c && ((estado_q == PUERTA) || ((estado_q == REPOSO) && en));
   assign arriba_c       = hay_arriba(MAX_PISOS'(pend_q), MAX_PISO_W'(piso_q));
   assign abajo_c        = hay_abajo(MAX_PISOS'(pend_q), MAX_PISO_W'(piso_q));
   assign dec_c          = decidir(arriba_c, abajo_c, dir_q);
   assign nuevo_c        = (estado_q == BAJANDO) ? (piso_q - PISO_W'(1)) : (piso_q + PISO_W'(1));
   assign llegada_pend_c = (32'(nuevo_c) < N_PISOS) && pend_q[nuevo_c];

   // Next-state, call latch and timer control
   always_comb begin
      estado_d  = estado_q;
      piso_d    = piso_q;
      dir_d     = dir_q;
      pend_d    = pend_q;
      tmr_load  = 1'b0;
      tmr_dec   = 1'b0;
      tmr_val   = '0;

      // Calls latch regardless of en; a call at an open or idle car's own floor is served directly
      if (llamada_ok_c && !absorbe_c) pend_d[sol_piso] = 1'b1;

      if (en) begin
         case (estado_q)
            REPOSO: begin
               if (misma_c || pend_q[piso_q]) begin
                  estado_d         = PUERTA;
                  pend_d[piso_q]   = 1'b0;
                  tmr_load         = 1'b1;
                  tmr_val          = TMR_W'(T_PUERTA);
               end else if (|pend_q) begin
                  estado_d = dec_c.estado;
                  dir_d    = dec_c.dir;
                  tmr_load = 1'b1;
                  tmr_val  = TMR_W'(T_VIAJE);
               end
            end
            SUBIENDO, BAJANDO: begin
               if (tmr_expira_c) begin
                  piso_d   = nuevo_c;
                  tmr_load = 1'b1;
                  if (llegada_pend_c) begin
                     estado_d        = PUERTA;
                     pend_d[nuevo_c] = 1'b0;
                     tmr_val         = TMR_W'(T_PUERTA);
                  end else begin
                     tmr_val = TMR_W'(T_VIAJE);
                  end
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            PUERTA: begin
               if (misma_c) begin
                  tmr_load = 1'b1;
                  tmr_val  = TMR_W'(T_PUERTA);
               end else if (tmr_expira_c) begin
                  estado_d = dec_c.estado;
                  dir_d    = dec_c.dir;
                  tmr_load = 1'b1;
                  tmr_val  = (dec_c.estado == REPOSO) ? '0 : TMR_W'(T_VIAJE);
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            default: ;
         endcase
      end

      puertas_d = (estado_d == PUERTA);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado_q  <= REPOSO;
         piso_q    <= '0;
         dir_q     <= DIR_SUBE;
         pend_q    <= '0;
         puertas_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         piso_q    <= piso_d;
         dir_q     <= dir_d;
         pend_q    <= pend_d;
         puertas_q <= puertas_d;
      end
   end

   assign piso       = piso_q;
   assign accion     = estado_q;
   assign puertas    = puertas_q;
   assign pendientes = pend_q;

   // The car must never be heading past the top or bottom floor
   a_movimiento_legal: assert property (@(posedge clk) disable iff (!rst)
      !(((estado_q == SUBIENDO) && (32'(piso_q) >= N_PISOS - 1)) ||
        ((estado_q == BAJANDO)  && (piso_q == '0))));

endmodule

// File: tb/tb_maquina_estados_scan.sv
// Bench for maquina_estados_scan: directed scenarios plus random calls against a floor-level model.
module tb_maquina_estados_scan;

   localparam int unsigned N  = 5;
   localparam int unsigned PW = $clog2(N);
   localparam int          TV = 2;
   localparam int          TP = 4;

   localparam int M_IDLE = 0;
   localparam int M_MOVE = 1;
   localparam int M_DOOR = 2;

   logic          clk;
   logic          rst;
   logic          en;
   logic          sol_valida;
   logic [PW-1:0] sol_piso;
   logic [PW-1:0] piso;
   logic [1:0]    accion;
   logic          puertas;
   logic [N-1:0]  pendientes;

   int checks   = 0;
   int failures = 0;

   // Reference model: floor number, activity, last direction (+1/-1), cycles left, call set
   int m_floor;
   int m_mode;
   int m_dir;
   int m_left;
   bit m_calls [N];

   maquina_estados_scan #(
      .N_PISOS  (N),
      .T_VIAJE  (TV),
      .T_PUERTA (TP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .sol_valida (sol_valida),
      .sol_piso   (sol_piso),
      .piso       (piso),
      .accion     (accion),
      .puertas    (puertas),
      .pendientes (pendientes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
      end
   endtask

   task automatic model_reset();
      m_floor = 0;
      m_mode  = M_IDLE;
      m_dir   = 1;
      m_left  = 0;
      for (int i = 0; i < int'(N); i++) m_calls[i] = 1'b0;
   endtask

   function automatic bit any_toward(input bit c [N], input int from, input int d);
      for (int i = 0; i < int'(N); i++) begin
         if (c[i] && ((i - from) * d > 0)) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic m_choose(input bit c [N]);
      if (any_toward(c, m_floor, m_dir)) begin
         m_mode = M_MOVE;
         m_left = TV;
      end else if (any_toward(c, m_floor, -m_dir)) begin
         m_dir  = -m_dir;
         m_mode = M_MOVE;
         m_left = TV;
      end else begin
         m_mode = M_IDLE;
      end
   endtask

   task automatic model_edge(input logic v, input logic [PW-1:0] p, input logic e);
      bit old [N];
      bit in_rng;
      bit at_cur;
      bit absorb;
      int stop_at;
      old     = m_calls;
      in_rng  = v && (int'(p) < int'(N));
      at_cur  = in_rng && (int'(p) == m_floor);
      absorb  = at_cur && ((m_mode == M_DOOR) || ((m_mode == M_IDLE) && e));
      stop_at = -1;
      if (e) begin
         case (m_mode)
            M_IDLE: begin
               if (at_cur || old[m_floor]) begin
                  m_mode  = M_DOOR;
                  m_left  = TP;
                  stop_at = m_floor;
               end else begin
                  m_choose(old);
               end
            end
            M_MOVE: begin
               if (m_left == 1) begin
                  m_floor = m_floor + m_dir;
                  if (m_floor >= 0 && m_floor < int'(N) && old[m_floor]) begin
                     m_mode  = M_DOOR;
                     m_left  = TP;
                     stop_at = m_floor;
                  end else begin
                     m_left = TV;
                  end
               end else begin
                  m_left = m_left - 1;
               end
            end
            default: begin
               if (at_cur) m_left = TP;
               else if (m_left == 1) m_choose(old);
               else m_left = m_left - 1;
            end
         endcase
      end
      if (in_rng && !absorb) m_calls[p] = 1'b1;
      if (stop_at >= 0) m_calls[stop_at] = 1'b0;
   endtask

   function automatic logic [1:0] exp_accion();
      if (m_mode == M_IDLE) return 2'b00;
      if (m_mode == M_DOOR) return 2'b11;
      return (m_dir > 0) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [N-1:0] exp_mask();
      logic [N-1:0] r;
      for (int i = 0; i < int'(N); i++) r[i] = m_calls[i];
      return r;
   endfunction

   task automatic check_model(input string tag);
      chk({tag, "_piso"},    32'(piso),       32'(m_floor));
      chk({tag, "_accion"},  32'(accion),     32'(exp_accion()));
      chk({tag, "_puertas"}, 32'(puertas),    32'(m_mode == M_DOOR));
      chk({tag, "_pend"},    32'(pendientes), 32'(exp_mask()));
      chk({tag, "_rango"},   32'(int'(piso) < int'(N)), 32'(1));
   endtask

   // Drive one cycle of inputs, advance model on the edge, compare just after it
   task automatic step(input string tag, input logic v, input logic [PW-1:0] p, input logic e);
      sol_valida = v;
      sol_piso   = p;
      en         = e;
      @(posedge clk);
      model_edge(v, p, e);
      #1;
      check_model(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst        = 1'b0;
      sol_valida = 1'b0;
      sol_piso   = '0;
      en         = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_piso",    32'(piso),       32'(0));
      chk("rst_accion",  32'(accion),     32'(0));
      chk("rst_puertas", 32'(puertas),    32'(0));
      chk("rst_pend",    32'(pendientes), 32'(0));
      rst = 1'b1;
   endtask

   initial begin
      int   stops [$];
      bit   saw_down;
      bit   prev_door;
      bit   sent0;
      bit   found;
      logic v;
      logic [PW-1:0] p;
      logic e;

      rst        = 1'b0;
      en         = 1'b1;
      sol_valida = 1'b0;
      sol_piso   = '0;
      model_reset();

      // Reset then idle with no calls
      do_reset();
      for (int c = 0; c < 20; c++) begin
         step("idle", 1'b0, '0, 1'b1);
         chk("idle_accion", 32'(accion), 32'(0));
         chk("idle_pend",   32'(pendientes), 32'(0));
      end

      // Single call to floor 3 from floor 0
      step("up_k", 1'b1, PW'(3), 1'b1);
      chk("up_k_pend",   32'(pendientes), 32'h08);
      chk("up_k_accion", 32'(accion), 32'(0));
      for (int c = 1; c <= 11; c++) begin
         step("up", 1'b0, '0, 1'b1);
         if (c == 1) chk("up_k1_accion", 32'(accion), 32'(1));
         if (c == 6) chk("up_k6_piso", 32'(piso), 32'(2));
         if (c == 7) begin
            chk("up_k7_piso",    32'(piso), 32'(3));
            chk("up_k7_accion",  32'(accion), 32'(3));
            chk("up_k7_puertas", 32'(puertas), 32'(1));
            chk("up_k7_pend",    32'(pendientes), 32'(0));
         end
         if (c == 10) chk("up_k10_puertas", 32'(puertas), 32'(1));
         if (c == 11) begin
            chk("up_k11_accion",  32'(accion), 32'(0));
            chk("up_k11_puertas", 32'(puertas), 32'(0));
         end
      end

      // SCAN order: 3 then 1 while leaving 0, then 0 requested at floor 2
      do_reset();
      step("scan_a", 1'b1, PW'(3), 1'b1);
      step("scan_b", 1'b1, PW'(1), 1'b1);
      chk("scan_start_accion", 32'(accion), 32'(1));
      chk("scan_start_piso",   32'(piso), 32'(0));
      saw_down  = 1'b0;
      prev_door = 1'b0;
      sent0     = 1'b0;
      for (int c = 0; c < 40; c++) begin
         v = 1'b0;
         if (!sent0 && (piso == PW'(2))) begin
            v     = 1'b1;
            sent0 = 1'b1;
         end
         step("scan", v, '0, 1'b1);
         if (puertas && !prev_door) stops.push_back(int'(piso));
         if (accion == 2'b10) saw_down = 1'b1;
         prev_door = puertas;
      end
      chk("scan_nstops", 32'(stops.size()), 32'(3));
      if (stops.size() == 3) begin
         chk("scan_stop0", 32'(stops[0]), 32'(1));
         chk("scan_stop1", 32'(stops[1]), 32'(3));
         chk("scan_stop2", 32'(stops[2]), 32'(0));
      end
      chk("scan_bajando", 32'(saw_down), 32'(1));
      chk("scan_end_accion", 32'(accion), 32'(0));

      // Door extension by a call at the open floor
      do_reset();
      step("ext_call", 1'b1, PW'(2), 1'b1);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         step("ext_wait", 1'b0, '0, 1'b1);
         if (puertas) found = 1'b1;
      end
      chk("ext_timeout", 32'(found), 32'(1));
      chk("ext_piso", 32'(piso), 32'(2));
      step("ext_d1", 1'b0, '0, 1'b1);
      step("ext_d2", 1'b1, PW'(2), 1'b1);
      chk("ext_pend",    32'(pendientes), 32'(0));
      chk("ext_puertas", 32'(puertas), 32'(1));
      for (int c = 0; c < 3; c++) begin
         step("ext_hold", 1'b0, '0, 1'b1);
         chk("ext_hold_puertas", 32'(puertas), 32'(1));
      end
      step("ext_close", 1'b0, '0, 1'b1);
      chk("ext_close_puertas", 32'(puertas), 32'(0));
      chk("ext_close_accion",  32'(accion), 32'(0));

      // Freeze mid-travel, calls still latched, out-of-range ignored
      do_reset();
      step("frz_call", 1'b1, PW'(3), 1'b1);
      step("frz_a", 1'b0, '0, 1'b1);
      step("frz_b", 1'b0, '0, 1'b1);
      for (int c = 0; c < 5; c++) begin
         v = (c == 0) || (c == 2) || (c == 3);
         p = (c == 0) ? PW'(1) : ((c == 2) ? PW'(7) : PW'(5));
         step("frz", v, p, 1'b0);
         chk("frz_piso",   32'(piso), 32'(0));
         chk("frz_accion", 32'(accion), 32'(1));
         chk("frz_pend",   32'(pendientes), 32'h0A);
      end
      step("frz_resume", 1'b0, '0, 1'b1);
      chk("frz_resume_piso",   32'(piso), 32'(1));
      chk("frz_resume_accion", 32'(accion), 32'(3));
      chk("frz_resume_pend",   32'(pendientes), 32'h08);
      step("oor", 1'b1, PW'(7), 1'b1);
      chk("oor_pend", 32'(pendientes), 32'h08);

      // Asynchronous reset while travelling up at floor 2
      do_reset();
      step("ar_call", 1'b1, PW'(4), 1'b1);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         step("ar_wait", (c == 1), PW'(1), 1'b1);
         if (piso == PW'(2)) found = 1'b1;
      end
      chk("ar_timeout", 32'(found), 32'(1));
      chk("ar_pre_accion", 32'(accion), 32'(1));
      #2;
      rst        = 1'b0;
      sol_valida = 1'b0;
      model_reset();
      #1;
      chk("ar_piso",    32'(piso), 32'(0));
      chk("ar_accion",  32'(accion), 32'(0));
      chk("ar_puertas", 32'(puertas), 32'(0));
      chk("ar_pend",    32'(pendientes), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 4; c++) step("ar_after", 1'b0, '0, 1'b1);

      // Random calls and enable against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         v = ($urandom_range(0, 6) == 0);
         p = PW'($urandom_range(0, 7));
         e = ($urandom_range(0, 11) != 0);
         step("rnd", v, p, e);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/maquina_estados_scan.md
Name: maquina_estados_scan

Overview:
Parametrised successor to the elevator controller. It serves an N_PISOS-floor car with a latched pending-call mask, a SCAN sweep policy, per-floor travel timing and a timed door.
It accepts one floor call per cycle from the panel/decoder layer and drives floor position, motion action and door outputs to the display and actuator logic.
Unlike the 4-floor generation, calls are stored until served, direction is kept across stops, and door time is extendable.

Parameters:
N_PISOS, 4, number of floors (2..16)
PISO_W, $clog2(N_PISOS), floor index width (derived, not overridden)
T_VIAJE, 2, clock cycles to travel one floor (>=1)
T_PUERTA, 4, clock cycles door stays open (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
en  input  1  run enable; 0 freezes motion, timers and state
sol_valida  input  1  floor call present this cycle
sol_piso  input  PISO_W  requested floor, sampled when sol_valida=1
piso  output  PISO_W  current floor of the car
accion  output  2  00 REPOSO, 01 SUBIENDO, 10 BAJANDO, 11 PUERTA
puertas  output  1  1 = door open
pendientes  output  N_PISOS  registered pending-call mask

Behaviour:
- Reset (rst=0, async): piso=0, accion=00, puertas=0, pendientes=0, timer=0, last direction=up. Reset mid-travel or with door open returns to these values immediately, and all pending calls are lost.
- Call latch: on an edge with sol_valida=1 and sol_piso<N_PISOS, set pendientes[sol_piso]. Out-of-range calls are ignored.
- Calls are latched even when en=0.
- A call for the current floor while in REPOSO or PUERTA does not set the bit. It opens the door, or restarts the door timer to T_PUERTA.
- The FSM decides from the registered pendientes. A call latched at edge k first influences state at edge k+1.
- FSM states: REPOSO, SUBIENDO, BAJANDO, PUERTA. accion is the state encoding. puertas=1 only in PUERTA.
- REPOSO: if any bit is pending, choose the next state with the same rule as door close.
- SUBIENDO and BAJANDO: the timer loads T_VIAJE on entry. It decrements each enabled cycle.
- When the timer reaches 1, the next edge does piso +/- 1 and then evaluates the new floor:
  - If pendientes[new piso]=1: clear the bit, go to PUERTA, timer=T_PUERTA.
  - Otherwise continue the same direction and reload the timer.
- Door close: at PUERTA timer expiry, evaluate in this order:
  1. Pending calls ahead in the last direction: move that way.
  2. Pending calls in the opposite direction: reverse and move.
  3. Neither: go to REPOSO.
- In REPOSO with no prior direction, up is preferred on ties.
- Simultaneous arrival and a new call for the same floor: the bit ends cleared, because that door opening serves it.
- Simultaneous calls at distinct cycles simply OR into the mask. There is no call cancel.
- Boundaries:
  - piso never exceeds N_PISOS-1 or drops below 0. SCAN guarantees a target exists ahead.
  - An assertion must flag any illegal move.
- en=0: state, piso, timer and outputs hold. Call latching continues.

Decomposition:
- Package ascensor_pkg:
  - accion/state encodings (REPOSO=2'b00, SUBIENDO=2'b01, BAJANDO=2'b10, PUERTA=2'b11)
  - direction constants
  - helper functions hay_arriba(mask, piso) and hay_abajo(mask, piso)
- Sub-module temporizador: loadable down-counter with en, load value and an expiry flag. It is shared by travel and door timing and sized to max(T_VIAJE, T_PUERTA).

Test Plan:
- Reset idle: rst low 2 cycles then high, no calls -> piso=0, accion=00, puertas=0, pendientes=0 held 20 cycles.
- Single call up: idle at 0, call floor 3 at edge k (defaults) -> pendientes=4'b1000 at k, accion=01 from k+1, piso=3 and accion=11, puertas=1, bit cleared at k+7, REPOSO at k+11.
- SCAN order: car moving up from 0 toward 3 with call 1 at piso=0 -> stops 1 then 3. Call 0 issued at floor 2 is served only after 3, via BAJANDO.
- Door extend: door open at floor 2, call floor 2 two cycles into door -> pendientes[2] stays 0, door stays open 4 cycles from that call.
- Freeze and out-of-range: en=0 mid-travel for 5 cycles -> piso/accion/timer unchanged, calls still latched. With N_PISOS=5, sol_piso=7 -> ignored.
- Async reset mid-travel: rst low between edges while SUBIENDO at piso=2 -> outputs at reset values before the next edge, pending mask cleared.
